// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate truth-table sweep controller.
// Reference truth tables are indexed by vector, so bit k is the gate output for input value k.
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;

   function automatic int nvec(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/gate_sweep_controller_if.sv
// Host/gate-side signal bundle of the sweep controller.
// The controller uses the slave modport; the host that starts sweeps and owns the gate uses master.
interface gate_sweep_controller_if
   import gate_sweep_pkg::*;
#(
   parameter int N_IN = 2
);
   localparam int NVEC = nvec(N_IN);

   logic              start;
   logic [NVEC-1:0]   expected_tt;
   logic              dut_q;
   logic [N_IN-1:0]   vec;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     err_cnt;
   logic [N_IN-1:0]   first_fail;

   modport master (
      output start, expected_tt, dut_q,
      input  vec, busy, done, pass, err_cnt, first_fail
   );

   modport slave (
      input  start, expected_tt, dut_q,
      output vec, busy, done, pass, err_cnt, first_fail
   );

endinterface

// File: rtl/gate_sweep_dwell_cnt.sv
// Dwell timer: clear/increment counter whose terminal-count flag marks the last cycle of a vector.
module gate_sweep_dwell_cnt #(
   parameter int DWELL = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic inc,
   output logic tc
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CW'(DWELL - 1));

endmodule

// File: rtl/gate_sweep_controller.sv
// Exhaustive truth-table sweep of a small combinational gate, with error count and first failing vector.
// Define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_sweep_controller
   import gate_sweep_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int DWELL = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gate_sweep_controller_if.slave bus
);
   localparam int NVEC = nvec(N_IN);
   localparam int EW   = N_IN + 1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   state_e          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;
   logic [EW-1:0]   err_cnt_q, err_cnt_d;
   logic [NVEC-1:0] tt_q, tt_d;
   logic            dwell_load, dwell_inc, dwell_tc;
   logic            mismatch, last_vec;

   gate_sweep_dwell_cnt #(.DWELL(DWELL)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (dwell_load),
      .inc   (dwell_inc),
      .tc    (dwell_tc)
   );

   // The gate output is judged only on the last cycle of each dwell window.
   assign mismatch = (state_q == RUN) && dwell_tc && (bus.dut_q != tt_q[vec_q]);
   assign last_vec = (vec_q == {N_IN{1'b1}});

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      first_fail_d = first_fail_q;
      err_cnt_d    = err_cnt_q;
      tt_d         = tt_q;
      dwell_load   = 1'b0;
      dwell_inc    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d      = RUN;
               vec_d        = '0;
               first_fail_d = '0;
               err_cnt_d    = '0;
               tt_d         = bus.expected_tt;
               dwell_load   = 1'b1;
            end
         end
         RUN: begin
            dwell_inc = 1'b1;
            if (dwell_tc) begin
               dwell_load = 1'b1;
               if (mismatch) begin
                  if (err_cnt_q != EW'(NVEC)) err_cnt_d = err_cnt_q + EW'(1);
                  if (err_cnt_q == '0) first_fail_d = vec_q;
               end
               if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                  state_d = DONE;
               end else begin
                  vec_d = vec_q + N_IN'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         first_fail_q <= '0;
         err_cnt_q    <= '0;
         tt_q         <= '0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         first_fail_q <= first_fail_d;
         err_cnt_q    <= err_cnt_d;
         tt_q         <= tt_d;
      end
   end

   assign bus.vec        = vec_q;
   assign bus.busy       = (state_q == RUN);
   assign bus.done       = (state_q == DONE);
   assign bus.pass       = (state_q == DONE) && (err_cnt_q == '0);
   assign bus.err_cnt    = err_cnt_q;
   assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Randomized bench for gate_sweep_controller with a truth-table level reference model.
// Honors GATE_SWEEP_STOP_ON_FAIL_EN the same way the design does.
module tb_gate_sweep_controller;
   import gate_sweep_pkg::*;

   localparam int N_IN  = 2;
   localparam int NVEC  = 4;
   localparam int DWELL = 4;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NVEC-1:0] gate_tt;
   int              checks = 0;
   int              failures = 0;

   gate_sweep_controller_if #(.N_IN(N_IN)) bus ();

   gate_sweep_controller #(.N_IN(N_IN), .DWELL(DWELL)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Gate under test: a combinational lookup of its own truth table.
   always_comb bus.dut_q = gate_tt[bus.vec];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vec"},   bus.vec, 0);
      chk({tag, "_busy"},  bus.busy, 0);
      chk({tag, "_done"},  bus.done, 0);
      chk({tag, "_pass"},  bus.pass, 0);
      chk({tag, "_err"},   bus.err_cnt, 0);
      chk({tag, "_ff"},    bus.first_fail, 0);
   endtask

   // Walk the truth tables vector by vector; nrun is how many vectors the sweep visits.
   task automatic model(input logic [NVEC-1:0] ett, input logic [NVEC-1:0] gtt,
                        output int nrun, output int errs, output int ff, output int lastv);
      errs = 0; ff = 0; nrun = NVEC; lastv = NVEC - 1;
      for (int k = 0; k < NVEC; k++) begin
         if (ett[k] != gtt[k]) begin
            if (errs == 0) ff = k;
            errs++;
            if (STOP) begin
               nrun = k + 1;
               lastv = k;
               break;
            end
         end
      end
   endtask

   // rst_at>0 pulls rst_n low in that cycle after the accepting edge and abandons the sweep.
   task automatic run_sweep(input string tag, input logic [NVEC-1:0] ett, input logic [NVEC-1:0] gtt,
                            input bit disturb, input int rst_at);
      int nrun, errs, ff, lastv, len;
      model(ett, gtt, nrun, errs, ff, lastv);
      len = nrun * DWELL;
      @(negedge clk);
      gate_tt = gtt;
      bus.expected_tt = ett;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.expected_tt = NVEC'($urandom);
      for (int c = 1; c <= len; c++) begin
         if (c == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_zero({tag, "_rst"});
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk_zero({tag, "_post_rst"});
            return;
         end
         chk({tag, "_busy"}, bus.busy, 1);
         chk({tag, "_done"}, bus.done, 0);
         chk({tag, "_vec"}, bus.vec, (c - 1) / DWELL);
         if (disturb && c == 5) begin
            bus.start = 1'b1;
            bus.expected_tt = TT_NOR2;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      chk({tag, "_end_done"}, bus.done, 1);
      chk({tag, "_end_busy"}, bus.busy, 0);
      chk({tag, "_pass"}, bus.pass, (errs == 0) ? 1 : 0);
      chk({tag, "_err_cnt"}, bus.err_cnt, errs);
      chk({tag, "_first_fail"}, bus.first_fail, ff);
      chk({tag, "_last_vec"}, bus.vec, lastv);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.expected_tt = '0;
      gate_tt = TT_NAND2;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("idle");

      run_sweep("nand_ok", TT_NAND2, TT_NAND2, 1'b0, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_done", bus.done, 1);
      chk("hold_pass", bus.pass, 1);
      chk("hold_vec", bus.vec, NVEC - 1);

      run_sweep("tied1", TT_NAND2, 4'b1111, 1'b0, 0);
      run_sweep("tied0", TT_NAND2, 4'b0000, 1'b0, 0);
      run_sweep("restart_ign", TT_NAND2, TT_NAND2, 1'b1, 0);
      run_sweep("abort", TT_NAND2, TT_NAND2, 1'b0, 9);
      run_sweep("after_rst", TT_NAND2, TT_NAND2, 1'b0, 0);
      run_sweep("b2b_nand", TT_NAND2, TT_NAND2, 1'b0, 0);
      run_sweep("b2b_xor", TT_XOR2, TT_NAND2, 1'b0, 0);
      run_sweep("and_vs_or", TT_AND2, TT_OR2, 1'b0, 0);

      for (int i = 0; i < 20; i++) begin
         run_sweep("rand", NVEC'($urandom), NVEC'($urandom), 1'($urandom_range(0, 1)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
